// File: rtl/latch_gate_arbiter.sv
// latch_gate_arbiter
//   Round-robin arbiter and write sequencer for one shared W-bit gated latch
//   bank. A granted requester's data is captured once onto ld_o, then the latch
//   gate lg_o is pulsed with programmed setup/pulse/hold spacing, and a one-cycle
//   done_o pulse is returned to that requester. A clear request runs a one-cycle
//   lclr_o pulse instead. This block is the only driver of ld_o/lg_o/lclr_o.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous reset, active-high
//   req_i       per-requester write request (level, held until done)
//   din_i       requester data; requester i on din_i[i*W +: W]
//   clr_req_i   latch-clear request (level, held until clr_done_o)
//   gnt_o       one-hot grant, high for the whole transaction
//   done_o      one-cycle completion pulse to the granted requester
//   clr_done_o  one-cycle completion pulse for a clear
//   ld_o        latch data
//   lg_o        latch gate
//   lclr_o      latch clear (held high during reset)
//   busy_o      high whenever the sequencer is not idle
module latch_gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] din_i,
  input  logic              clr_req_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              clr_done_o,
  output logic [W-1:0]      ld_o,
  output logic              lg_o,
  output logic              lclr_o,
  output logic              busy_o
);

  localparam int MAXP = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                        : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int CW = $clog2(MAXP) + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);
  localparam logic [CW-1:0]   SETUP_LD  = CW'(SETUP - 1);
  localparam logic [CW-1:0]   PULSE_LD  = CW'(PULSE - 1);
  localparam logic [CW-1:0]   HOLD_LD   = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SETUP = 3'd2,
    S_GATE  = 3'd3,
    S_HOLD  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   gidx_q;
  logic            is_clr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            clr_done_q;
  logic [W-1:0]    ld_q;
  logic            lg_q;
  logic            lclr_q;
  logic            busy_q;

  logic [IW-1:0]   cand_s;
  logic [IW-1:0]   win_idx_s;
  logic            win_vld_s;
  logic [IW-1:0]   rr_d;

  // Round-robin pick: first set request scanning upward from rr_q with wrap.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = {IW{1'b0}};
    cand_s    = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(rr_q) + k) % NREQ);
      if (!win_vld_s && req_i[cand_s]) begin
        win_vld_s = 1'b1;
        win_idx_s = cand_s;
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Pointer value after serving gidx_q: the requester just above it, wrapped.
  always_comb begin
    rr_d = IW'((int'(gidx_q) + 1) % NREQ);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      rr_q       <= {IW{1'b0}};
      gidx_q     <= {IW{1'b0}};
      is_clr_q   <= 1'b0;
      gnt_q      <= {NREQ{1'b0}};
      done_q     <= {NREQ{1'b0}};
      clr_done_q <= 1'b0;
      ld_q       <= {W{1'b0}};
      lg_q       <= 1'b0;
      lclr_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // Pulse outputs default low; only the transition into ACK/CLEAR raises them.
      done_q     <= {NREQ{1'b0}};
      clr_done_q <= 1'b0;
      lclr_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          lg_q <= 1'b0;
          if (clr_req_i) begin
            // Clear wins over writes in the same cycle.
            state_q  <= S_CLEAR;
            lclr_q   <= 1'b1;
            is_clr_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (win_vld_s) begin
            // Data is captured exactly once here; later din_i changes are ignored.
            state_q  <= S_SETUP;
            gnt_q    <= GNT_ONE << win_idx_s;
            gidx_q   <= win_idx_s;
            ld_q     <= din_i[win_idx_s*W +: W];
            cnt_q    <= SETUP_LD;
            is_clr_q <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q    <= S_ACK;
          clr_done_q <= 1'b1;
        end
        S_SETUP: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= S_GATE;
            lg_q    <= 1'b1;
            cnt_q   <= PULSE_LD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_GATE: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= S_HOLD;
            lg_q    <= 1'b0;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= S_ACK;
            done_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_ACK: begin
          state_q  <= S_IDLE;
          gnt_q    <= {NREQ{1'b0}};
          busy_q   <= 1'b0;
          is_clr_q <= 1'b0;
          // A clear does not move the fairness pointer.
          if (!is_clr_q) begin
            rr_q <= rr_d;
          end else begin
            rr_q <= rr_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= {NREQ{1'b0}};
          lg_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign clr_done_o = clr_done_q;
  assign ld_o       = ld_q;
  assign lg_o       = lg_q;
  assign lclr_o     = lclr_q;
  assign busy_o     = busy_q;

endmodule
